// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage redirect, instruction-memory and IF/ID bundle
interface fetch_stage_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     redirect_valid;
    logic [ADDRESS_WIDTH-1:0] redirect_target;
    logic [ADDRESS_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0]    imem_rdata;
    logic                     id_valid;
    logic                     id_ready;
    logic [DATA_WIDTH-1:0]    id_instr;
    logic [ADDRESS_WIDTH-1:0] id_pc;
    logic [ADDRESS_WIDTH-1:0] id_pc_plus4;
    logic                     halted;
    logic [ADDRESS_WIDTH-1:0] fault_addr;

    // Fetch-stage side: owns the PC, the IF/ID register and the halt status.
    modport master (
        input  redirect_valid, redirect_target, imem_rdata, id_ready,
        output imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, halted, fault_addr
    );

    // Surrounding side: execute, instruction memory and decode.
    modport slave (
        output redirect_valid, redirect_target, imem_rdata, id_ready,
        input  imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, halted, fault_addr
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RISC-V instruction fetch stage with IF/ID register and halt on misaligned redirect
module fetch_stage #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic                     id_valid_q, id_valid_d;
    logic [DATA_WIDTH-1:0]    id_instr_q, id_instr_d;
    logic [ADDRESS_WIDTH-1:0] id_pc_q, id_pc_d;
    logic [ADDRESS_WIDTH-1:0] id_pc_plus4_q, id_pc_plus4_d;
    logic [ADDRESS_WIDTH-1:0] fault_q, fault_d;

    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic                     target_misaligned;
    logic                     load;

    // pc+4 wraps naturally at the top of the address space.
    assign pc_plus4          = pc_q + ADDRESS_WIDTH'(4);
    assign target_misaligned = bus.redirect_target[1:0] != 2'b00;
    assign load              = !id_valid_q || bus.id_ready;

    assign bus.imem_addr   = pc_q;
    assign bus.id_valid    = id_valid_q;
    assign bus.id_instr    = id_instr_q;
    assign bus.id_pc       = id_pc_q;
    assign bus.id_pc_plus4 = id_pc_plus4_q;
    assign bus.halted      = (state_q == ST_HALT);
    assign bus.fault_addr  = fault_q;

    // Next-state: redirect beats fetch; a flush drops the held slot even if decode is ready.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        fault_d       = fault_q;
        if (state_q == ST_RUN) begin
            if (bus.redirect_valid && target_misaligned) begin
                state_d    = ST_HALT;
                fault_d    = bus.redirect_target;
                id_valid_d = 1'b0;
            end else if (bus.redirect_valid) begin
                pc_d       = bus.redirect_target;
                id_valid_d = 1'b0;
            end else if (load) begin
                id_instr_d    = bus.imem_rdata;
                id_pc_d       = pc_q;
                id_pc_plus4_d = pc_plus4;
                id_valid_d    = 1'b1;
                pc_d          = pc_plus4;
            end
        end else begin
            id_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_instr_q    <= '0;
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
            fault_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            fault_q       <= fault_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a transaction-level model
module tb_fetch_stage;
    logic clk;
    logic rst_n;

    fetch_stage_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) b  ();
    fetch_stage_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) b2 ();

    fetch_stage #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    fetch_stage #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_top (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );

    // Instruction memory: word i holds 0x100 + i.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h100 + (addr >> 2);
    endfunction

    assign b.imem_rdata  = mem_word(b.imem_addr);
    assign b2.imem_rdata = mem_word(b2.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: expected PC, slot contents and halt status.
    logic [31:0] m_pc, m_instr, m_idpc, m_fault;
    logic        m_v, m_halt;

    task automatic model_reset();
        m_pc = 32'h0; m_v = 1'b0; m_instr = 32'h0; m_idpc = 32'h0;
        m_halt = 1'b0; m_fault = 32'h0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".imem_addr"}, b.imem_addr, m_pc);
        check({tag, ".id_valid"}, {31'b0, b.id_valid}, {31'b0, m_v});
        check({tag, ".halted"}, {31'b0, b.halted}, {31'b0, m_halt});
        check({tag, ".fault_addr"}, b.fault_addr, m_fault);
        if (m_v) begin
            check({tag, ".id_pc"}, b.id_pc, m_idpc);
            check({tag, ".id_instr"}, b.id_instr, m_instr);
            check({tag, ".id_pc_plus4"}, b.id_pc_plus4, m_idpc + 32'd4);
        end
    endtask

    // One clock with the given inputs; model advances at the edge, outputs sampled on negedge.
    task automatic step(input logic rstn, input logic rv, input logic [31:0] tgt, input logic rdy,
                        input string tag);
        rst_n             = rstn;
        b.redirect_valid  = rv;
        b.redirect_target = tgt;
        b.id_ready        = rdy;
        @(posedge clk);
        if (!rstn) begin
            model_reset();
        end else if (!m_halt) begin
            if (rv && tgt[1:0] != 2'b00) begin
                m_halt = 1'b1; m_fault = tgt; m_v = 1'b0;
            end else if (rv) begin
                m_pc = tgt; m_v = 1'b0;
            end else if (!m_v || rdy) begin
                m_instr = mem_word(m_pc); m_idpc = m_pc; m_v = 1'b1; m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk);
        compare_all(tag);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_reset();
        rst_n = 1'b0;
        b.redirect_valid = 1'b0; b.redirect_target = 32'h0; b.id_ready = 1'b1;
        b2.redirect_valid = 1'b0; b2.redirect_target = 32'h0; b2.id_ready = 1'b1;

        // Reset and stream three instructions.
        step(1'b0, 1'b0, 32'h0, 1'b1, "rst0");
        step(1'b0, 1'b0, 32'h0, 1'b1, "rst1");
        check("rst.id_instr", b.id_instr, 32'h0);
        check("rst.id_pc", b.id_pc, 32'h0);
        check("rst.id_pc_plus4", b.id_pc_plus4, 32'h0);
        check("top.first_addr", b2.imem_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0, 1'b1, "s0");
        check("s0.pc", b.id_pc, 32'h0);
        check("s0.instr", b.id_instr, 32'h100);
        check("top.id_pc", b2.id_pc, 32'hFFFF_FFFC);
        check("top.id_pc_plus4", b2.id_pc_plus4, 32'h0);
        check("top.wrap_addr", b2.imem_addr, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1, "s1");
        check("s1.pc", b.id_pc, 32'h4);
        check("s1.instr", b.id_instr, 32'h101);
        step(1'b1, 1'b0, 32'h0, 1'b1, "s2");
        check("s2.pc", b.id_pc, 32'h8);
        check("s2.instr", b.id_instr, 32'h102);

        // Back-pressure holds the slot and the PC.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0, "stall");
            check("stall.id_pc", b.id_pc, 32'h8);
            check("stall.addr", b.imem_addr, 32'hC);
        end
        step(1'b1, 1'b0, 32'h0, 1'b1, "resume");
        check("resume.id_pc", b.id_pc, 32'hC);

        // Redirect while stalled flushes the slot.
        step(1'b1, 1'b1, 32'h40, 1'b0, "redir");
        check("redir.id_valid", {31'b0, b.id_valid}, 32'h0);
        check("redir.addr", b.imem_addr, 32'h40);
        step(1'b1, 1'b0, 32'h0, 1'b0, "redir_fetch");
        check("redir.id_pc", b.id_pc, 32'h40);
        check("redir.id_pc_plus4", b.id_pc_plus4, 32'h44);

        // Reset wins over a simultaneous redirect.
        step(1'b1, 1'b0, 32'h0, 1'b1, "pre_rst");
        step(1'b0, 1'b1, 32'h40, 1'b1, "rst_redir");
        check("rst_redir.addr", b.imem_addr, 32'h0);
        check("rst_redir.id_valid", {31'b0, b.id_valid}, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1, "post_rst");
        check("post_rst.id_pc", b.id_pc, 32'h0);

        // Randomized traffic, including simultaneous redirect+ready and occasional misaligned targets.
        for (int i = 0; i < 400; i++) begin
            logic        rstn, rv, rdy;
            logic [31:0] tgt;
            rstn = ($urandom_range(0, 31) != 0);
            rv   = ($urandom_range(0, 5) == 0);
            rdy  = ($urandom_range(0, 2) != 0);
            tgt  = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            step(rstn, rv, tgt, rdy, "rand");
        end

        // Misaligned redirect halts until reset.
        step(1'b0, 1'b0, 32'h0, 1'b1, "h_rst");
        step(1'b1, 1'b0, 32'h0, 1'b1, "h_pre");
        step(1'b1, 1'b1, 32'h42, 1'b1, "halt");
        check("halt.halted", {31'b0, b.halted}, 32'h1);
        check("halt.fault", b.fault_addr, 32'h42);
        check("halt.id_valid", {31'b0, b.id_valid}, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1, "halt_idle");
        step(1'b1, 1'b1, 32'h80, 1'b1, "halt_redir");
        check("halt_redir.addr", b.imem_addr, 32'h4);
        check("halt_redir.halted", {31'b0, b.halted}, 32'h1);
        step(1'b0, 1'b0, 32'h0, 1'b1, "halt_rst");
        check("halt_rst.halted", {31'b0, b.halted}, 32'h0);
        check("halt_rst.addr", b.imem_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
